// File: rtl/rv32_exec_unit_pkg.sv
// Shared encodings for the execute stage: ALU operations, operand-B sources and branch types.
package rv32_exec_unit_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [1:0] BSRC_BUSB = 2'b00;
   localparam logic [1:0] BSRC_IMM  = 2'b01;
   localparam logic [1:0] BSRC_FOUR = 2'b10;
   localparam logic [1:0] BSRC_ZERO = 2'b11;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_JAL  = 3'b001;
   localparam logic [2:0] BR_JALR = 3'b010;
   localparam logic [2:0] BR_RSVD = 3'b011;
   localparam logic [2:0] BR_BEQ  = 3'b100;
   localparam logic [2:0] BR_BNE  = 3'b101;
   localparam logic [2:0] BR_BLT  = 3'b110;
   localparam logic [2:0] BR_BGE  = 3'b111;

endpackage

// File: rtl/rv32_alu_core.sv
// Combinational RV32I ALU: result plus compare/equality flags derived from the same operands.
module rv32_alu_core
   import rv32_exec_unit_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [3:0]  i_aluctr,
   output logic [31:0] o_result,
   output logic        o_less,
   output logic        o_zero
);

   logic [4:0] w_shamt;
   logic       w_less_s;
   logic       w_less_u;

   assign w_shamt  = i_b[4:0];
   assign w_less_s = $signed(i_a) < $signed(i_b);
   assign w_less_u = i_a < i_b;

   // The flag follows the unsigned compare only for SLTU; every other code reports the signed view.
   assign o_less = (i_aluctr == ALU_SLTU) ? w_less_u : w_less_s;
   assign o_zero = (i_a == i_b);

   always_comb begin
      o_result = 32'd0;
      case (i_aluctr)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_SLL:  o_result = i_a << w_shamt;
         ALU_SLT:  o_result = {31'd0, w_less_s};
         ALU_SLTU: o_result = {31'd0, w_less_u};
         ALU_LUI:  o_result = i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SRL:  o_result = i_a >> w_shamt;
         ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
         ALU_OR:   o_result = i_a | i_b;
         ALU_AND:  o_result = i_a & i_b;
         default:  o_result = 32'd0;
      endcase
   end

endmodule

// File: rtl/rv32_exec_unit.sv
// Execute stage: operand muxes, ALU, branch resolution into next-PC selects, and the stage output register.
module rv32_exec_unit
   import rv32_exec_unit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] busA,
   input  logic [31:0] busB,
   input  logic [31:0] PC,
   input  logic [31:0] imm,
   input  logic        ALUAsrc,
   input  logic [1:0]  ALUBsrc,
   input  logic [3:0]  ALUctr,
   input  logic [2:0]  Branch,
   output logic [31:0] ALUout,
   output logic        less,
   output logic        zero,
   output logic        PCAsrc,
   output logic        PCBsrc
);

   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [31:0] w_result;
   logic        w_less;
   logic        w_zero;
   logic        w_pcasrc;
   logic        w_pcbsrc;

   logic [31:0] r_aluout;
   logic        r_less;
   logic        r_zero;
   logic        r_pcasrc;
   logic        r_pcbsrc;

   assign w_a = ALUAsrc ? PC : busA;

   always_comb begin
      w_b = busB;
      case (ALUBsrc)
         BSRC_BUSB: w_b = busB;
         BSRC_IMM:  w_b = imm;
         BSRC_FOUR: w_b = 32'd4;
         BSRC_ZERO: w_b = 32'd0;
         default:   w_b = busB;
      endcase
   end

   rv32_alu_core u_alu (
      .i_a      (w_a),
      .i_b      (w_b),
      .i_aluctr (ALUctr),
      .o_result (w_result),
      .o_less   (w_less),
      .o_zero   (w_zero)
   );

   // Branch decisions use this cycle's combinational flags, not the registered copies.
   always_comb begin
      w_pcasrc = 1'b0;
      w_pcbsrc = 1'b0;
      case (Branch)
         BR_NONE: begin w_pcasrc = 1'b0;    w_pcbsrc = 1'b0; end
         BR_JAL:  begin w_pcasrc = 1'b1;    w_pcbsrc = 1'b0; end
         BR_JALR: begin w_pcasrc = 1'b1;    w_pcbsrc = 1'b1; end
         BR_RSVD: begin w_pcasrc = 1'b0;    w_pcbsrc = 1'b0; end
         BR_BEQ:  begin w_pcasrc = w_zero;  w_pcbsrc = 1'b0; end
         BR_BNE:  begin w_pcasrc = ~w_zero; w_pcbsrc = 1'b0; end
         BR_BLT:  begin w_pcasrc = w_less;  w_pcbsrc = 1'b0; end
         BR_BGE:  begin w_pcasrc = ~w_less; w_pcbsrc = 1'b0; end
         default: begin w_pcasrc = 1'b0;    w_pcbsrc = 1'b0; end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_aluout <= 32'd0;
         r_less   <= 1'b0;
         r_zero   <= 1'b0;
         r_pcasrc <= 1'b0;
         r_pcbsrc <= 1'b0;
      end else begin
         r_aluout <= w_result;
         r_less   <= w_less;
         r_zero   <= w_zero;
         r_pcasrc <= w_pcasrc;
         r_pcbsrc <= w_pcbsrc;
      end
   end

   assign ALUout = r_aluout;
   assign less   = r_less;
   assign zero   = r_zero;
   assign PCAsrc = r_pcasrc;
   assign PCBsrc = r_pcbsrc;

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Bench for rv32_exec_unit: directed vector table, reset sequences, and random stimulus against a reference model.
module tb_rv32_exec_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] busA = '0;
   logic [31:0] busB = '0;
   logic [31:0] PC = '0;
   logic [31:0] imm = '0;
   logic        ALUAsrc = 1'b0;
   logic [1:0]  ALUBsrc = '0;
   logic [3:0]  ALUctr = '0;
   logic [2:0]  Branch = '0;
   logic [31:0] ALUout;
   logic        less;
   logic        zero;
   logic        PCAsrc;
   logic        PCBsrc;

   int checks = 0;
   int errors = 0;

   rv32_exec_unit dut (
      .clock   (clock),
      .reset   (reset),
      .busA    (busA),
      .busB    (busB),
      .PC      (PC),
      .imm     (imm),
      .ALUAsrc (ALUAsrc),
      .ALUBsrc (ALUBsrc),
      .ALUctr  (ALUctr),
      .Branch  (Branch),
      .ALUout  (ALUout),
      .less    (less),
      .zero    (zero),
      .PCAsrc  (PCAsrc),
      .PCBsrc  (PCBsrc)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] a, b, pc, im;
      logic        asrc;
      logic [1:0]  bsrc;
      logic [3:0]  ctr;
      logic [2:0]  br;
      logic [31:0] out;
      logic        lt, eq, pca, pcb;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [31:0] out, input logic lt,
                            input logic eq, input logic pca, input logic pcb);
      check({name, ".ALUout"}, ALUout, out);
      check({name, ".less"},   {31'd0, less},   {31'd0, lt});
      check({name, ".zero"},   {31'd0, zero},   {31'd0, eq});
      check({name, ".PCAsrc"}, {31'd0, PCAsrc}, {31'd0, pca});
      check({name, ".PCBsrc"}, {31'd0, PCBsrc}, {31'd0, pcb});
   endtask

   task automatic drive(input logic [31:0] a, b, pc, im, input logic asrc,
                        input logic [1:0] bsrc, input logic [3:0] ctr, input logic [2:0] br);
      busA = a; busB = b; PC = pc; imm = im;
      ALUAsrc = asrc; ALUBsrc = bsrc; ALUctr = ctr; Branch = br;
   endtask

   // Reference model: instruction semantics computed directly from operand values.
   task automatic model(input logic [31:0] a_in, b_in, pc, im, input logic asrc,
                        input logic [1:0] bsrc, input logic [3:0] ctr, input logic [2:0] br,
                        output logic [31:0] out, output logic lt, eq, pca, pcb);
      logic [31:0] a, b;
      longint sa, sb;
      int sh;
      a = asrc ? pc : a_in;
      b = (bsrc == 2'd0) ? b_in : (bsrc == 2'd1) ? im : (bsrc == 2'd2) ? 32'd4 : 32'd0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      case (ctr)
         4'd0:  out = a + b;
         4'd8:  out = a - b;
         4'd1:  out = 32'((64'(a) * (64'd1 << sh)));
         4'd2:  out = (sa < sb) ? 32'd1 : 32'd0;
         4'd10: out = (a < b) ? 32'd1 : 32'd0;
         4'd3:  out = b;
         4'd4:  out = a ^ b;
         4'd5:  out = a / (32'd1 << sh);
         4'd13: out = 32'((sa - ((sa % (longint'(1) << sh) + (longint'(1) << sh)) % (longint'(1) << sh))) / (longint'(1) << sh));
         4'd6:  out = a | b;
         4'd7:  out = a & b;
         default: out = 32'd0;
      endcase
      lt = (ctr == 4'd10) ? (a < b) : (sa < sb);
      eq = (a == b);
      pcb = (br == 3'd2);
      case (br)
         3'd1, 3'd2: pca = 1'b1;
         3'd4: pca = eq;
         3'd5: pca = !eq;
         3'd6: pca = lt;
         3'd7: pca = !lt;
         default: pca = 1'b0;
      endcase
   endtask

   function automatic vec_t mk(string n, logic [31:0] a, b, pc, im, logic asrc, logic [1:0] bsrc,
                               logic [3:0] ctr, logic [2:0] br, logic [31:0] out,
                               logic lt, eq, pca, pcb);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.pc = pc; v.im = im; v.asrc = asrc; v.bsrc = bsrc;
      v.ctr = ctr; v.br = br; v.out = out; v.lt = lt; v.eq = eq; v.pca = pca; v.pcb = pcb;
      return v;
   endfunction

   initial begin
      logic [31:0] e_out;
      logic e_lt, e_eq, e_pca, e_pcb;

      vecs.push_back(mk("add",     32'd5, 32'd7, 0, 0, 0, 2'b00, 4'b0000, 3'b000, 32'd12, 1, 0, 0, 0));
      vecs.push_back(mk("beq",     32'h12345678, 32'h12345678, 0, 0, 0, 2'b00, 4'b1000, 3'b100, 32'd0, 0, 1, 1, 0));
      vecs.push_back(mk("bne",     32'h12345678, 32'h12345678, 0, 0, 0, 2'b00, 4'b1000, 3'b101, 32'd0, 0, 1, 0, 0));
      vecs.push_back(mk("slt",     32'h80000000, 32'd1, 0, 0, 0, 2'b00, 4'b0010, 3'b000, 32'd1, 1, 0, 0, 0));
      vecs.push_back(mk("sltu",    32'h80000000, 32'd1, 0, 0, 0, 2'b00, 4'b1010, 3'b000, 32'd0, 0, 0, 0, 0));
      vecs.push_back(mk("bgeu",    32'h80000000, 32'd1, 0, 0, 0, 2'b00, 4'b1010, 3'b111, 32'd0, 0, 0, 1, 0));
      vecs.push_back(mk("blt",     32'h80000000, 32'd1, 0, 0, 0, 2'b00, 4'b0010, 3'b110, 32'd1, 1, 0, 1, 0));
      vecs.push_back(mk("sll",     32'hF0000000, 32'h24, 0, 0, 0, 2'b00, 4'b0001, 3'b000, 32'h0, 1, 0, 0, 0));
      vecs.push_back(mk("srl",     32'hF0000000, 32'h24, 0, 0, 0, 2'b00, 4'b0101, 3'b000, 32'h0F000000, 1, 0, 0, 0));
      vecs.push_back(mk("sra",     32'hF0000000, 32'h24, 0, 0, 0, 2'b00, 4'b1101, 3'b000, 32'hFF000000, 1, 0, 0, 0));
      vecs.push_back(mk("sll32",   32'd1, 32'd32, 0, 0, 0, 2'b00, 4'b0001, 3'b000, 32'd1, 1, 0, 0, 0));
      vecs.push_back(mk("pc_four", 0, 0, 32'h100, 32'h20, 1, 2'b10, 4'b0000, 3'b000, 32'h104, 0, 0, 0, 0));
      vecs.push_back(mk("pc_imm",  0, 0, 32'h100, 32'h20, 1, 2'b01, 4'b0000, 3'b000, 32'h120, 0, 0, 0, 0));
      vecs.push_back(mk("lui",     0, 0, 32'h100, 32'h20, 1, 2'b01, 4'b0011, 3'b000, 32'h20, 0, 0, 0, 0));
      vecs.push_back(mk("jal",     32'd1, 32'd2, 0, 0, 0, 2'b00, 4'b0000, 3'b001, 32'd3, 1, 0, 1, 0));
      vecs.push_back(mk("jalr",    32'd1, 32'd2, 0, 0, 0, 2'b00, 4'b0000, 3'b010, 32'd3, 1, 0, 1, 1));
      vecs.push_back(mk("rsvd",    32'd1, 32'd2, 0, 0, 0, 2'b00, 4'b0000, 3'b011, 32'd3, 1, 0, 0, 0));
      vecs.push_back(mk("badop",   32'd1, 32'd2, 0, 0, 0, 2'b00, 4'b1111, 3'b000, 32'd0, 1, 0, 0, 0));

      // Reset asserted with no clock edge must clear outputs immediately.
      #2 reset = 1'b1;
      #1 check_all("reset", 32'd0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].im, vecs[i].asrc,
               vecs[i].bsrc, vecs[i].ctr, vecs[i].br);
         @(posedge clock);
         #1 check_all(vecs[i].name, vecs[i].out, vecs[i].lt, vecs[i].eq, vecs[i].pca, vecs[i].pcb);
         @(negedge clock);
      end

      // Mid-stream reset: registered result is cleared without a clock edge.
      drive(32'h12345678, 32'h12345678, 0, 0, 0, 2'b00, 4'b0000, 3'b010);
      @(posedge clock);
      #1 check_all("pre_rst", 32'h2468ACF0, 0, 1, 1, 1);
      @(negedge clock);
      reset = 1'b1;
      #1 check_all("mid_rst", 32'd0, 0, 0, 0, 0);
      @(posedge clock);
      #1 check_all("held_rst", 32'd0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
      drive(32'd9, 32'd3, 0, 0, 0, 2'b00, 4'b1000, 3'b000);
      @(posedge clock);
      #1 check_all("post_rst", 32'd6, 0, 0, 0, 0);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra, rb;
         @(negedge clock);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = ra;
         if ($urandom_range(0, 3) == 0) rb = {27'($urandom), 5'($urandom)} & 32'h3F;
         drive(ra, rb, $urandom, $urandom, 1'($urandom), 2'($urandom), 4'($urandom), 3'($urandom));
         model(busA, busB, PC, imm, ALUAsrc, ALUBsrc, ALUctr, Branch, e_out, e_lt, e_eq, e_pca, e_pcb);
         @(posedge clock);
         #1 check_all($sformatf("rand%0d", n), e_out, e_lt, e_eq, e_pca, e_pcb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
